// File: rtl/hamming_stream_decoder.sv
// hamming_stream_decoder
//   Two-stage pipelined Hamming (2^R-1, 2^R-R-1) decoder/corrector on a
//   valid/ready stream, with saturating error statistics for the host.
//
//   Codeword layout: position p (1..N) is in_cw[N-p]. Power-of-two positions
//   carry even parity. The remaining positions carry data in ascending
//   position order, MSB first.
//
//   Optional build macro HAMMING_SECDED_EN: in_cw gains an overall even-parity
//   bit at in_cw[N]. Double errors are then flagged on out_uncorr instead of
//   being miscorrected. Without the macro, out_uncorr and uncorr_count are
//   constant 0.
//
//   Handshake: a word moves across an interface on a rising edge where both
//   valid and ready are high. A held output (out_valid & !out_ready) keeps
//   every out_* field stable. in_ready is combinational from pipeline
//   occupancy and out_ready.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   input stream handshake
//   in_cw [CW]          codeword (CW = N, or N+1 in SECDED builds)
//   out_valid/out_ready output stream handshake
//   out_data [K]        corrected data word
//   out_corr            a single-bit error was corrected
//   out_uncorr          uncorrectable error (SECDED builds only)
//   out_syn [R]         raw syndrome of the received word
//   clear_counts        synchronous clear of both counters (wins over increment)
//   corr_count,
//   uncorr_count [CNT_W] saturating per-word error counts
module hamming_stream_decoder #(
   parameter int R     = 4,
   parameter int CNT_W = 16,
   localparam int N    = (1 << R) - 1,
   localparam int K    = N - R,
`ifdef HAMMING_SECDED_EN
   localparam int CW   = N + 1
`else
   localparam int CW   = N
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [CW-1:0]    in_cw,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [K-1:0]     out_data,
   output logic             out_corr,
   output logic             out_uncorr,
   output logic [R-1:0]     out_syn,
   input  logic             clear_counts,
   output logic [CNT_W-1:0] corr_count,
   output logic [CNT_W-1:0] uncorr_count
);

   if (R < 3 || R > 6) begin : g_bad_r
      $error("hamming_stream_decoder: R must be in 3..6");
   end

   logic             s1_valid, s2_valid;
   logic             adv1, adv2;
   logic [N-1:0]     s1_cw;
   logic [R-1:0]     s1_syn, in_syn;
   logic             flip, corr_n;
   logic [N-1:0]     fixed_cw;
   logic [K-1:0]     data_n;
   logic             out_fire;

   assign adv2      = !s2_valid || out_ready;
   assign adv1      = !s1_valid || adv2;
   assign in_ready  = adv1;
   assign out_valid = s2_valid;
   assign out_fire  = s2_valid && out_ready;

   // Syndrome: XOR of the position numbers of every set bit.
   always_comb begin
      in_syn = '0;
      for (int p = 1; p <= N; p++) begin
         if (in_cw[N-p]) in_syn = in_syn ^ p[R-1:0];
      end
   end

`ifdef HAMMING_SECDED_EN
   logic s1_par;
   logic uncorr_n;
   logic s2_uncorr;

   // Overall parity decides single vs. double error; S=0 with P=1 means the
   // overall bit itself flipped, so data needs no change.
   always_comb begin
      corr_n   = 1'b0;
      uncorr_n = 1'b0;
      flip     = 1'b0;
      if (s1_par) begin
         corr_n = 1'b1;
         flip   = (s1_syn != '0);
      end else if (s1_syn != '0) begin
         uncorr_n = 1'b1;
      end
   end

   assign out_uncorr = s2_uncorr;
`else
   // Without the overall bit every nonzero syndrome is taken as one error.
   always_comb begin
      corr_n = (s1_syn != '0);
      flip   = corr_n;
   end

   assign out_uncorr = 1'b0;
`endif

   // Correct the flagged position, then gather the non-parity positions.
   always_comb begin
      int j;
      fixed_cw = s1_cw;
      for (int p = 1; p <= N; p++) begin
         if (flip && (s1_syn == p[R-1:0])) fixed_cw[N-p] = ~s1_cw[N-p];
      end
      data_n = '0;
      j      = K - 1;
      for (int p = 1; p <= N; p++) begin
         if ((p & (p - 1)) != 0) begin
            data_n[j] = fixed_cw[N-p];
            j         = j - 1;
         end
      end
   end

   // Stage 1: codeword and syndrome. in_cw is only captured on a real
   // transfer so an idle (possibly X) bus never reaches state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_cw    <= '0;
         s1_syn   <= '0;
`ifdef HAMMING_SECDED_EN
         s1_par   <= 1'b0;
`endif
      end else if (adv1) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_cw  <= in_cw[N-1:0];
            s1_syn <= in_syn;
`ifdef HAMMING_SECDED_EN
            s1_par <= ^in_cw;
`endif
         end
      end
   end

   // Stage 2: decoded word and flags; holds while stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         out_data  <= '0;
         out_corr  <= 1'b0;
         out_syn   <= '0;
`ifdef HAMMING_SECDED_EN
         s2_uncorr <= 1'b0;
`endif
      end else if (adv2) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            out_data  <= data_n;
            out_corr  <= corr_n;
            out_syn   <= s1_syn;
`ifdef HAMMING_SECDED_EN
            s2_uncorr <= uncorr_n;
`endif
         end
      end
   end

   // Statistics count delivered words only; clear has priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         corr_count   <= '0;
         uncorr_count <= '0;
      end else if (clear_counts) begin
         corr_count   <= '0;
         uncorr_count <= '0;
      end else if (out_fire) begin
         if (out_corr && (corr_count != {CNT_W{1'b1}}))
            corr_count <= corr_count + 1'b1;
         if (out_uncorr && (uncorr_count != {CNT_W{1'b1}}))
            uncorr_count <= uncorr_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hamming_stream_decoder.sv
// tb_hamming_stream_decoder
//   Bench for hamming_stream_decoder (R=4). Two instances share the stimulus:
//   dut (CNT_W=16) and dut_s (CNT_W=4, for counter saturation). Expected words
//   come from an encoder/error-injection model and travel in exp_q.
//   Honours HAMMING_SECDED_EN for the codeword width and directed vectors.
module tb_hamming_stream_decoder;

   localparam int R = 4;
   localparam int N = (1 << R) - 1;
   localparam int K = N - R;
   localparam int W = K + 2 + R;
`ifdef HAMMING_SECDED_EN
   localparam int CW = N + 1;
`else
   localparam int CW = N;
`endif

   logic          clk, rst;
   logic          in_valid, in_ready, in_ready_s;
   logic [CW-1:0] in_cw;
   logic          out_valid, out_valid_s, out_ready;
   logic [K-1:0]  out_data, out_data_s;
   logic          out_corr, out_corr_s, out_uncorr, out_uncorr_s;
   logic [R-1:0]  out_syn, out_syn_s;
   logic          clear_counts;
   logic [15:0]   corr_count, uncorr_count;
   logic [3:0]    corr_count_s, uncorr_count_s;

   int            checks, errors;
   logic [W-1:0]  exp_q[$];
   int            stall_cnt;
   bit            rnd_ready, rnd_clear, clr_on_out, force_clr;
   int            model_corr, model_uncorr;
   bit            prev_stalled;
   logic [W-1:0]  prev_word;

   hamming_stream_decoder #(.R(R), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_cw(in_cw), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_corr(out_corr), .out_uncorr(out_uncorr),
      .out_syn(out_syn), .clear_counts(clear_counts),
      .corr_count(corr_count), .uncorr_count(uncorr_count));

   hamming_stream_decoder #(.R(R), .CNT_W(4)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
      .in_cw(in_cw), .out_valid(out_valid_s), .out_ready(out_ready),
      .out_data(out_data_s), .out_corr(out_corr_s), .out_uncorr(out_uncorr_s),
      .out_syn(out_syn_s), .clear_counts(clear_counts),
      .corr_count(corr_count_s), .uncorr_count(uncorr_count_s));

   // ---------------- clock / watchdog ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [N-1:0] encode(input logic [K-1:0] d);
      logic [N:1] b;
      logic       par;
      int         j;
      b = '0;
      j = K - 1;
      for (int p = 1; p <= N; p++)
         if ((p & (p - 1)) != 0) begin b[p] = d[j]; j--; end
      for (int i = 0; i < R; i++) begin
         par = 1'b0;
         for (int p = 1; p <= N; p++) if (((p >> i) & 1) == 1) par ^= b[p];
         b[1 << i] = par;
      end
      for (int p = 1; p <= N; p++) encode[N-p] = b[p];
   endfunction

   function automatic logic [K-1:0] extract(input logic [N-1:0] c);
      int j;
      extract = '0;
      j = K - 1;
      for (int p = 1; p <= N; p++)
         if ((p & (p - 1)) != 0) begin extract[j] = c[N-p]; j--; end
   endfunction

   function automatic logic [31:0] sat(input int v, input int w);
      int m;
      m = (1 << w) - 1;
      return (v > m) ? m : v;
   endfunction

   function automatic logic [CW-1:0] mk_cw(input logic [N-1:0] c);
`ifdef HAMMING_SECDED_EN
      return {^c, c};
`else
      return c;
`endif
   endfunction

   // Random data word with nerr injected errors; expected word from the rules.
   task automatic gen(input int nerr, output logic [CW-1:0] cw, output logic [W-1:0] e);
      logic [31:0]  r;
      logic [K-1:0] d;
      logic [R-1:0] s;
      int           p1, p2;
      r  = $urandom;
      d  = r[K-1:0];
      cw = mk_cw(encode(d));
`ifdef HAMMING_SECDED_EN
      // position 0 denotes the overall parity bit at cw[N]
      p1 = $urandom_range(0, N);
      p2 = p1;
      while (p2 == p1) p2 = $urandom_range(0, N);
      s = '0;
      if (nerr >= 1) begin cw[(p1 == 0) ? N : N - p1] ^= 1'b1; s ^= p1[R-1:0]; end
      if (nerr == 2) begin cw[(p2 == 0) ? N : N - p2] ^= 1'b1; s ^= p2[R-1:0]; end
      if (nerr == 0)      e = {d, 1'b0, 1'b0, s};
      else if (nerr == 1) e = {d, 1'b1, 1'b0, s};
      else                e = {extract(cw[N-1:0]), 1'b0, 1'b1, s};
`else
      p1 = $urandom_range(1, N);
      p2 = 0;
      if (nerr != 0) begin
         cw[N-p1] ^= 1'b1;
         s = p1[R-1:0];
         e = {d, 1'b1, 1'b0, s};
      end else begin
         s = '0;
         e = {d, 1'b0, 1'b0, s};
      end
`endif
   endtask

   // ---------------- check helper ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input bit v, input logic [CW-1:0] cw, input logic [W-1:0] e,
                        output bit acc);
      @(negedge clk);
      in_valid = v;
      in_cw    = v ? cw : {CW{1'bx}};
      if (stall_cnt > 0) begin
         out_ready = 1'b0;
         stall_cnt--;
      end else begin
         out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      clear_counts = force_clr || (clr_on_out && out_valid) ||
                     (rnd_clear && ($urandom_range(0, 15) == 0));
      #1;
      acc = v && in_ready;
      if (acc) exp_q.push_back(e);
   endtask

   task automatic send(input logic [CW-1:0] cw, input logic [W-1:0] e);
      bit acc;
      int n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 200) begin
         cycle(1'b1, cw, e, acc);
         n++;
      end
      if (!acc) chk("send_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      bit acc;
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0, acc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 500) begin idle(1); n++; end
      chk("drain_empty", exp_q.size(), 0);
   endtask

   // ---------------- scoreboard / monitor ----------------
   always begin : monitor
      logic [W-1:0] e, word, word_s;
      bit           fire;
      @(negedge clk);
      #2;
      word   = {out_data, out_corr, out_uncorr, out_syn};
      word_s = {out_data_s, out_corr_s, out_uncorr_s, out_syn_s};
      if (rst) begin
         model_corr   = 0;
         model_uncorr = 0;
         prev_stalled = 1'b0;
      end else begin
         chk("corr_count",     corr_count,     sat(model_corr, 16));
         chk("uncorr_count",   uncorr_count,   sat(model_uncorr, 16));
         chk("corr_count_s",   corr_count_s,   sat(model_corr, 4));
         chk("uncorr_count_s", uncorr_count_s, sat(model_uncorr, 4));
         if (prev_stalled) begin
            chk("stall_hold_valid", out_valid, 1);
            chk("stall_hold_word", word, prev_word);
         end
         fire = out_valid && out_ready;
         e    = '0;
         if (fire) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", word, {W{1'b1}} ^ word);
               fire = 1'b0;
            end else begin
               e = exp_q.pop_front();
               chk("out_word", word, e);
               chk("out_word_s", word_s, e);
            end
         end
         if (clear_counts) begin
            model_corr   = 0;
            model_uncorr = 0;
         end else if (fire) begin
            model_corr   += int'(e[R+1]);
            model_uncorr += int'(e[R]);
         end
         prev_stalled = out_valid && !out_ready;
         prev_word    = word;
      end
   end

   // ---------------- directed + random sequence ----------------
   initial begin : stim
      logic [CW-1:0] cw;
      logic [W-1:0]  e;
      bit            acc;
      checks = 0; errors = 0;
      rst = 1'b1; in_valid = 1'b0; in_cw = '0; out_ready = 1'b0;
      clear_counts = 1'b0; stall_cnt = 0;
      rnd_ready = 1'b0; rnd_clear = 1'b0; clr_on_out = 1'b0; force_clr = 1'b0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_corr", out_corr, 0);
      chk("rst_out_uncorr", out_uncorr, 0);
      chk("rst_out_syn", out_syn, 0);
      chk("rst_corr_count", corr_count, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("in_ready_after_rst", in_ready, 1);

`ifdef HAMMING_SECDED_EN
      send(16'hE881, {11'h001, 1'b0, 1'b0, 4'd0});
      idle(1);
      chk("lat_cycle1_valid", out_valid, 0);
      idle(1);
      chk("lat_cycle2_valid", out_valid, 1);
      chk("lat_cycle2_data", out_data, 11'h001);
      send(16'h6881, {11'h001, 1'b1, 1'b0, 4'd0});
      send(16'hA880, {11'h000, 1'b0, 1'b1, 4'd14});
      drain();
      chk("secded_corr_count", corr_count, 1);
      chk("secded_uncorr_count", uncorr_count, 1);
`else
      send(15'h6881, {11'h001, 1'b0, 1'b0, 4'd0});
      idle(1);
      chk("lat_cycle1_valid", out_valid, 0);
      idle(1);
      chk("lat_cycle2_valid", out_valid, 1);
      chk("lat_cycle2_data", out_data, 11'h001);
      chk("lat_cycle2_syn", out_syn, 0);
      send(15'h7881, {11'h001, 1'b1, 1'b0, 4'd3});
      drain();
      chk("single_corr_count", corr_count, 1);
`endif

      // back-pressure: 8 clean words, output stalled for 5 cycles
      stall_cnt = 5;
      for (int i = 0; i < 8; i++) begin
         e  = {i[K-1:0], 1'b0, 1'b0, 4'd0};
         cw = mk_cw(encode(i[K-1:0]));
         if (i == 2) begin
            cycle(1'b1, cw, e, acc);
            chk("bp_in_ready_low", acc, 0);
         end
         send(cw, e);
      end
      drain();

      // random traffic with random stalls, gaps and clears
      rnd_ready = 1'b1;
      rnd_clear = 1'b1;
      for (int i = 0; i < 300; i++) begin
`ifdef HAMMING_SECDED_EN
         gen($urandom_range(0, 2), cw, e);
`else
         gen($urandom_range(0, 1), cw, e);
`endif
         if ($urandom_range(0, 3) == 0) idle(1);
         send(cw, e);
      end
      rnd_ready = 1'b0;
      rnd_clear = 1'b0;
      drain();

      // saturation of the 4-bit counter, then clear racing an increment
      force_clr = 1'b1;
      idle(1);
      force_clr = 1'b0;
      for (int i = 0; i < 20; i++) begin
         gen(1, cw, e);
         send(cw, e);
      end
      drain();
      chk("sat_corr_count_s", corr_count_s, 15);
      chk("sat_corr_count", corr_count, 20);
      gen(1, cw, e);
      send(cw, e);
      clr_on_out = 1'b1;
      drain();
      clr_on_out = 1'b0;
      idle(1);
      chk("clear_wins_corr", corr_count, 0);
      chk("clear_wins_corr_s", corr_count_s, 0);

      // reset with two words in flight
      for (int i = 0; i < 3; i++) begin
         gen(1, cw, e);
         send(cw, e);
      end
      drain();
      stall_cnt = 10;
      gen(1, cw, e);
      send(cw, e);
      gen(1, cw, e);
      send(cw, e);
      @(negedge clk);
      rst      = 1'b1;
      in_valid = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_corr_count", corr_count, 0);
      chk("midrst_corr_count_s", corr_count_s, 0);
      chk("midrst_uncorr_count", uncorr_count, 0);
      chk("midrst_out_data", out_data, 0);
      chk("midrst_out_corr", out_corr, 0);
      @(negedge clk);
      rst       = 1'b0;
      stall_cnt = 0;
      #1;
      chk("midrst_in_ready", in_ready, 1);
      for (int i = 0; i < 4; i++) begin
         idle(1);
         chk("no_stale_valid", out_valid, 0);
      end

      drain();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
